// File: rtl/counter_sweep_ctrl.sv
// Triangle-sweep sequencer for an external CW-bit up/down counter (timed or limit-bounded).
// Optional SWEEP_OVF_GUARD_EN: timed mode reverses before the counter wraps and flags ovf_hit.
module counter_sweep_ctrl #(
  parameter int CW = 4,
  parameter int DW = 8,
  parameter int NW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          mode,
  input  logic [DW-1:0] up_len,
  input  logic [DW-1:0] dn_len,
  input  logic [CW-1:0] lo_lim,
  input  logic [CW-1:0] hi_lim,
  input  logic [NW-1:0] num_sweeps,
  input  logic [CW-1:0] count,
  output logic          up_dnb,
  output logic          cnt_en,
  output logic          busy,
  output logic          done,
  output logic [NW-1:0] sweeps_done,
`ifdef SWEEP_OVF_GUARD_EN
  output logic          ovf_hit,
`endif
  output logic          cfg_err
);

  typedef enum logic [1:0] {S_IDLE, S_UP, S_DOWN, S_DONE} state_t;

  localparam logic [CW-1:0] CNT_MAX_M1 = {{(CW-1){1'b1}}, 1'b0};

  state_t        r_state, w_state_nx;
  logic [DW-1:0] r_dwell, w_dwell_nx;
  logic          r_up_dnb, w_up_dnb_nx;
  logic          r_cnt_en, w_cnt_en_nx;
  logic          r_busy, w_busy_nx;
  logic          r_done, w_done_nx;
  logic [NW-1:0] r_sweeps, w_sweeps_nx, w_sweeps_inc;
  logic          r_cfg_err, w_cfg_err_nx;
  logic          r_ovf, w_ovf_nx;

  logic [DW-1:0] w_up_len_eff, w_dn_len_eff;
  logic [CW:0]   w_count_x, w_lo_x, w_hi_x;
  logic          w_cfg_bad, w_up_guard, w_dn_guard, w_up_turn, w_dn_turn;

  // Limits compared one bit wider so hi_lim-1 / lo_lim+1 never wrap.
  assign w_count_x    = {1'b0, count};
  assign w_lo_x       = {1'b0, lo_lim};
  assign w_hi_x       = {1'b0, hi_lim};
  assign w_cfg_bad    = (w_hi_x <= w_lo_x + (CW+1)'(1));
  assign w_up_len_eff = (up_len == '0) ? DW'(1) : up_len;
  assign w_dn_len_eff = (dn_len == '0) ? DW'(1) : dn_len;
  assign w_sweeps_inc = r_sweeps + NW'(1);

`ifdef SWEEP_OVF_GUARD_EN
  assign w_up_guard = !mode && (count == CNT_MAX_M1);
  assign w_dn_guard = !mode && (count == CW'(1));
`else
  assign w_up_guard = 1'b0;
  assign w_dn_guard = 1'b0;
`endif

  assign w_up_turn = mode ? (w_count_x + (CW+1)'(1) >= w_hi_x)
                          : ((r_dwell >= w_up_len_eff) || w_up_guard);
  assign w_dn_turn = mode ? (w_count_x <= w_lo_x + (CW+1)'(1))
                          : ((r_dwell >= w_dn_len_eff) || w_dn_guard);

  always_comb begin
    // NOTE: every next-value gets a hold default first so no path infers a latch.
    w_state_nx   = r_state;
    w_dwell_nx   = r_dwell;
    w_up_dnb_nx  = r_up_dnb;
    w_cnt_en_nx  = r_cnt_en;
    w_busy_nx    = r_busy;
    w_done_nx    = 1'b0;
    w_sweeps_nx  = r_sweeps;
    w_cfg_err_nx = r_cfg_err;
    w_ovf_nx     = r_ovf;

    unique case (r_state)
      S_IDLE: begin
        if (start && !stop) begin
          if (mode && w_cfg_bad) begin
            w_cfg_err_nx = 1'b1;
          end else begin
            w_state_nx   = S_UP;
            w_dwell_nx   = DW'(1);
            w_up_dnb_nx  = 1'b1;
            w_cnt_en_nx  = 1'b1;
            w_busy_nx    = 1'b1;
            w_sweeps_nx  = '0;
            w_cfg_err_nx = 1'b0;
            w_ovf_nx     = 1'b0;
          end
        end
      end
      S_UP: begin
        if (stop) begin
          w_state_nx  = S_IDLE;
          w_up_dnb_nx = 1'b1;
          w_cnt_en_nx = 1'b0;
          w_busy_nx   = 1'b0;
        end else if (w_up_turn) begin
          w_state_nx  = S_DOWN;
          w_dwell_nx  = DW'(1);
          w_up_dnb_nx = 1'b0;
          w_ovf_nx    = r_ovf | w_up_guard;
        end else if (r_dwell != '1) begin
          w_dwell_nx = r_dwell + DW'(1);
        end
      end
      S_DOWN: begin
        if (stop) begin
          w_state_nx  = S_IDLE;
          w_up_dnb_nx = 1'b1;
          w_cnt_en_nx = 1'b0;
          w_busy_nx   = 1'b0;
        end else if (w_dn_turn) begin
          w_sweeps_nx = w_sweeps_inc;
          w_up_dnb_nx = 1'b1;
          w_dwell_nx  = DW'(1);
          w_ovf_nx    = r_ovf | w_dn_guard;
          if ((num_sweeps != '0) && (w_sweeps_inc == num_sweeps)) begin
            w_state_nx  = S_DONE;
            w_done_nx   = 1'b1;
            w_cnt_en_nx = 1'b0;
            w_busy_nx   = 1'b0;
          end else begin
            w_state_nx = S_UP;
          end
        end else if (r_dwell != '1) begin
          w_dwell_nx = r_dwell + DW'(1);
        end
      end
      S_DONE: begin
        w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      r_state   <= S_IDLE;
      r_dwell   <= '0;
      r_up_dnb  <= 1'b1;
      r_cnt_en  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_sweeps  <= '0;
      r_cfg_err <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_dwell   <= w_dwell_nx;
      r_up_dnb  <= w_up_dnb_nx;
      r_cnt_en  <= w_cnt_en_nx;
      r_busy    <= w_busy_nx;
      r_done    <= w_done_nx;
      r_sweeps  <= w_sweeps_nx;
      r_cfg_err <= w_cfg_err_nx;
      r_ovf     <= w_ovf_nx;
    end
  end

  assign up_dnb      = r_up_dnb;
  assign cnt_en      = r_cnt_en;
  assign busy        = r_busy;
  assign done        = r_done;
  assign sweeps_done = r_sweeps;
  assign cfg_err     = r_cfg_err;
`ifdef SWEEP_OVF_GUARD_EN
  assign ovf_hit     = r_ovf;
`else
  logic w_ovf_unused;
  assign w_ovf_unused = r_ovf;
`endif

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Self-checking bench for counter_sweep_ctrl; models the external up/down counter and
// compares traces through a scoreboard queue filled when each sweep is launched.
module tb_counter_sweep_ctrl;

  localparam int CW = 4;
  localparam int DW = 8;
  localparam int NW = 8;

  logic          clk = 1'b0;
  logic          rst, start, stop, mode;
  logic [DW-1:0] up_len, dn_len;
  logic [CW-1:0] lo_lim, hi_lim;
  logic [NW-1:0] num_sweeps;
  logic [CW-1:0] cnt;
  logic          up_dnb, cnt_en, busy, done, cfg_err;
  logic [NW-1:0] sweeps_done;
  logic          ld;
  logic [CW-1:0] ld_val;
`ifdef SWEEP_OVF_GUARD_EN
  logic          ovf_hit;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  // Behavioural up/down counter fed by the sequencer.
  always @(posedge clk) begin
    if (ld)          cnt <= ld_val;
    else if (cnt_en) cnt <= up_dnb ? cnt + 4'd1 : cnt - 4'd1;
  end

  counter_sweep_ctrl #(.CW(CW), .DW(DW), .NW(NW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .up_len(up_len), .dn_len(dn_len), .lo_lim(lo_lim), .hi_lim(hi_lim),
    .num_sweeps(num_sweeps), .count(cnt), .up_dnb(up_dnb), .cnt_en(cnt_en),
    .busy(busy), .done(done), .sweeps_done(sweeps_done),
`ifdef SWEEP_OVF_GUARD_EN
    .ovf_hit(ovf_hit),
`endif
    .cfg_err(cfg_err)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_count(input logic [CW-1:0] v);
    ld = 1'b1; ld_val = v;
    tick();
    ld = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  int peak, seen_done;

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0; ld = 1'b0; ld_val = '0;
    up_len = 8'd6; dn_len = 8'd5; lo_lim = 4'd3; hi_lim = 4'd12; num_sweeps = 8'd2;
    tick(); tick();
    rst = 1'b0;
    check("rst_up_dnb", up_dnb, 1);
    check("rst_cnt_en", cnt_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sweeps", sweeps_done, 0);
    check("rst_cfg_err", cfg_err, 0);

    // 1: timed, two sweeps of 6 up / 5 down
    load_count(4'd0);
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 6; i++) exp_q.push_back(1);
      for (int i = 0; i < 5; i++) exp_q.push_back(0);
    end
    pulse_start();
    check("t1_busy", busy, 1);
    while (exp_q.size() > 0) begin
      check("t1_up_dnb", up_dnb, exp_q.pop_front());
      check("t1_no_early_done", done, 0);
      tick();
    end
    check("t1_done", done, 1);
    check("t1_sweeps", sweeps_done, 2);
    check("t1_busy_off", busy, 0);
    check("t1_cnt_en_off", cnt_en, 0);
    check("t1_count_end", cnt, 2);
    tick();
    check("t1_done_pulse", done, 0);
    check("t1_count_hold", cnt, 2);

    // 2: limit mode 3..12, one sweep
    mode = 1'b1; lo_lim = 4'd3; hi_lim = 4'd12; num_sweeps = 8'd1;
    load_count(4'd3);
    for (int v = 4; v <= 12; v++) exp_q.push_back(v);
    for (int v = 11; v >= 3; v--) exp_q.push_back(v);
    pulse_start();
    check("t2_count_start", cnt, 3);
    while (exp_q.size() > 0) begin
      tick();
      check("t2_count", cnt, exp_q.pop_front());
    end
    check("t2_done", done, 1);
    check("t2_busy_off", busy, 0);
    tick();
    check("t2_done_pulse", done, 0);
    check("t2_count_hold", cnt, 3);

    // 3: bad limits refuse start
    lo_lim = 4'd5; hi_lim = 4'd6;
    pulse_start();
    check("t3_cfg_err", cfg_err, 1);
    check("t3_busy", busy, 0);
    check("t3_cnt_en", cnt_en, 0);
    tick();
    check("t3_stays_idle", busy, 0);

    // 4: continuous, stop after 40 cycles; then start+stop together
    mode = 1'b0; up_len = 8'd3; dn_len = 8'd3; num_sweeps = 8'd0;
    pulse_start();
    check("t4_cfg_err_clr", cfg_err, 0);
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) seen_done++;
    end
    check("t4_no_done", seen_done, 0);
    check("t4_sweeps_run", sweeps_done, 6);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t4_stop_busy", busy, 0);
    check("t4_stop_cnt_en", cnt_en, 0);
    check("t4_stop_up_dnb", up_dnb, 1);
    check("t4_stop_done", done, 0);
    check("t4_sweeps_hold", sweeps_done, 6);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("t4_ss_busy", busy, 0);
    check("t4_ss_sweeps", sweeps_done, 6);

    // 5: reset in DOWN
    up_len = 8'd4; dn_len = 8'd4;
    pulse_start();
    for (int i = 0; i < 6; i++) tick();
    check("t5_in_down", up_dnb, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_up_dnb", up_dnb, 1);
    check("t5_cnt_en", cnt_en, 0);
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_sweeps", sweeps_done, 0);

    // 6: long timed UP from 0 -- guarded reversal or wrap
    up_len = 8'd20; dn_len = 8'd20; num_sweeps = 8'd1;
    load_count(4'd0);
    pulse_start();
    peak = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (int'(cnt) > peak) peak = int'(cnt);
    end
    check("t6_peak", peak, 15);
`ifdef SWEEP_OVF_GUARD_EN
    check("t6_count", cnt, 14);
    check("t6_up_dnb", up_dnb, 0);
    check("t6_ovf_hit", ovf_hit, 1);
    stop = 1'b1; tick(); stop = 1'b0;
    check("t6_ovf_sticky", ovf_hit, 1);
    pulse_start();
    check("t6_ovf_clr", ovf_hit, 0);
`else
    check("t6_count_wrap", cnt, 0);
    check("t6_up_dnb", up_dnb, 1);
`endif
    stop = 1'b1; tick(); stop = 1'b0;
    check("t6_stopped", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
